// File: rtl/prn_range_draw.sv
// Rejection-sampling draw of a uniform value in [0, RANGE-1] from the 5-bit LFSR bus, with a bounded-latency mod fallback.
// Optional no-repeat rule enabled by defining PRN_NO_REPEAT_EN.
module prn_range_draw #(
    parameter int RANGE     = 20,
    parameter int MAX_TRIES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] prn,
    input  logic       req,
    output logic       busy,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_value,
    output logic       fallback,
    output logic [7:0] draw_count
);
    localparam logic [5:0] RANGE_W  = 6'(RANGE);
    localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES - 1);

    typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_t;

    state_t     state_q, state_d;
    logic [3:0] tries_q, tries_d;
    logic [4:0] value_q, value_d;
    logic       fb_q, fb_d;
    logic [7:0] cnt_q, cnt_d;

    logic [4:0] prn_mod;
    logic [4:0] fb_value;
    logic       in_range;
    logic       repeat_hit;
    logic       legal;

    // Constant divisor, so this reduces to plain combinational logic.
    assign prn_mod  = 5'({1'b0, prn} % RANGE_W);
    assign in_range = ({1'b0, prn} < RANGE_W);

`ifdef PRN_NO_REPEAT_EN
    localparam bit REP_OK = (RANGE > 1);

    logic [4:0] last_value_q, last_value_d;
    logic       last_valid_q, last_valid_d;
    logic [4:0] last_next;
    logic       rep_active;

    assign rep_active = REP_OK && last_valid_q;
    assign last_next  = ((6'(last_value_q) + 6'd1) == RANGE_W) ? 5'd0 : last_value_q + 5'd1;
    assign repeat_hit = rep_active && (prn == last_value_q);
    assign fb_value   = (rep_active && (prn_mod == last_value_q)) ? last_next : prn_mod;
`else
    assign repeat_hit = 1'b0;
    assign fb_value   = prn_mod;
`endif

    assign legal = in_range && !repeat_hit;

    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        value_d = value_q;
        fb_d    = fb_q;
        cnt_d   = cnt_q;
`ifdef PRN_NO_REPEAT_EN
        last_value_d = last_value_q;
        last_valid_d = last_valid_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = DRAW;
                    tries_d = 4'd0;
                end
            end
            DRAW: begin
                if (legal) begin
                    value_d = prn;
                    fb_d    = 1'b0;
                    state_d = HOLD;
                end else if (tries_q == LAST_TRY) begin
                    value_d = fb_value;
                    fb_d    = 1'b1;
                    state_d = HOLD;
                end else begin
                    tries_d = tries_q + 4'd1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + 8'd1;
`ifdef PRN_NO_REPEAT_EN
                    last_value_d = value_q;
                    last_valid_d = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tries_q <= 4'd0;
            value_q <= 5'd0;
            fb_q    <= 1'b0;
            cnt_q   <= 8'd0;
`ifdef PRN_NO_REPEAT_EN
            last_value_q <= 5'd0;
            last_valid_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            value_q <= value_d;
            fb_q    <= fb_d;
            cnt_q   <= cnt_d;
`ifdef PRN_NO_REPEAT_EN
            last_value_q <= last_value_d;
            last_valid_q <= last_valid_d;
`endif
        end
    end

    assign busy       = (state_q != IDLE);
    assign out_valid  = (state_q == HOLD);
    assign out_value  = value_q;
    assign fallback   = fb_q;
    assign draw_count = cnt_q;
endmodule
